// File: rtl/rv_pkg.sv
// Shared fetch-stage definitions: datapath widths, reset PC default, the fetch
// FSM encoding and the fetched-instruction buffer entry.
package rv_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Instruction fetch addresses are always word aligned.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched instructions between the fetch FSM and
// decode. Flush empties it in one cycle and wins over push and pop.
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  fetch_entry_t                   push_entry,
    input  logic                           pop,
    input  logic                           flush,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output fetch_entry_t                   head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count_q;
    logic           do_push;
    logic           do_pop;

    assign do_pop  = pop && (count_q != '0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push && ((count_q != FULL) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign count = count_q;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one request in flight at a time, redirect handling
// with response kill, and a 2-entry buffer feeding decode.
module if_stage
    import rv_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [63:0]  imem_req_addr,
    input  logic         imem_rsp_valid,
    input  logic [31:0]  imem_rsp_data,
    input  logic         redirect_valid,
    input  logic [63:0]  redirect_pc,
    output logic         id_valid,
    input  logic         id_ready,
    output logic [31:0]  id_instr,
    output logic [63:0]  id_pc,
    output logic [6:0]   id_opcode,
    output fetch_state_e dbg_state
);

    // Handshakes: a transfer happens in any cycle where valid && ready; valid
    // never depends on ready, and the memory response has no backpressure.
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    fetch_state_e   state_q;
    fetch_state_e   state_d;
    logic [63:0]    pc_q;
    logic [63:0]    pc_d;
    logic           req_fire;
    logic           fifo_push;
    logic           fifo_pop;
    logic [CW-1:0]  fifo_count;
    fetch_entry_t   fifo_head;
    fetch_entry_t   push_entry;

    assign imem_req_valid = (state_q == IDLE) && (fifo_count < FIFO_FULL)
                            && !redirect_valid && !rst;
    assign imem_req_addr  = rst ? '0 : pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fifo_push = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_fire) state_d = WAIT;
            end
            WAIT: begin
                // A redirect makes the outstanding response stale: drop it now
                // if it is here, otherwise remember to drop it when it arrives.
                if (redirect_valid) begin
                    state_d = imem_rsp_valid ? IDLE : KILL;
                end else if (imem_rsp_valid) begin
                    state_d   = IDLE;
                    fifo_push = 1'b1;
                end
            end
            KILL: begin
                if (imem_rsp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (req_fire) begin
            pc_d = pc_q + 64'd4;
        end
    end

    // pc_q already points past the outstanding request while in WAIT.
    assign push_entry = '{pc: pc_q - 64'd4, instr: imem_rsp_data};
    assign fifo_pop   = id_valid && id_ready && !redirect_valid;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .flush      (redirect_valid),
        .count      (fifo_count),
        .head       (fifo_head)
    );

    assign id_valid  = (fifo_count != '0) && !rst;
    assign id_instr  = id_valid ? fifo_head.instr : '0;
    assign id_pc     = id_valid ? fifo_head.pc : '0;
    assign id_opcode = id_instr[6:0];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based fetch model.
module tb_if_stage;
    import rv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT with default reset PC
    logic         rst;
    logic         imem_req_valid;
    logic         imem_req_ready;
    logic [63:0]  imem_req_addr;
    logic         imem_rsp_valid;
    logic [31:0]  imem_rsp_data;
    logic         redirect_valid;
    logic [63:0]  redirect_pc;
    logic         id_valid;
    logic         id_ready;
    logic [31:0]  id_instr;
    logic [63:0]  id_pc;
    logic [6:0]   id_opcode;
    fetch_state_e dbg_state;

    // Second DUT whose reset PC sits at the top of the address space
    logic         w_rst;
    logic         w_req_valid;
    logic         w_req_ready;
    logic [63:0]  w_req_addr;
    logic         w_rsp_valid;
    logic [31:0]  w_rsp_data;
    logic         w_redirect_valid;
    logic [63:0]  w_redirect_pc;
    logic         w_id_valid;
    logic         w_id_ready;
    logic [31:0]  w_id_instr;
    logic [63:0]  w_id_pc;
    logic [6:0]   w_id_opcode;
    fetch_state_e w_dbg_state;

    if_stage u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_opcode      (id_opcode),
        .dbg_state      (dbg_state)
    );

    if_stage #(
        .RESET_PC (64'hFFFF_FFFF_FFFF_FFFC)
    ) u_wrap (
        .clk            (clk),
        .rst            (w_rst),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (w_req_ready),
        .imem_req_addr  (w_req_addr),
        .imem_rsp_valid (w_rsp_valid),
        .imem_rsp_data  (w_rsp_data),
        .redirect_valid (w_redirect_valid),
        .redirect_pc    (w_redirect_pc),
        .id_valid       (w_id_valid),
        .id_ready       (w_id_ready),
        .id_instr       (w_id_instr),
        .id_pc          (w_id_pc),
        .id_opcode      (w_id_opcode),
        .dbg_state      (w_dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst;
        bit          rdy;
        bit          rsp;
        logic [31:0] data;
        bit          redir;
        logic [63:0] rpc;
        bit          idr;
        bit          e_req;
        logic [63:0] e_addr;
        bit          e_idv;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    function automatic vec_t mk(bit r, bit rdy, bit rsp, logic [31:0] data, bit redir,
                                logic [63:0] rpc, bit idr, bit e_req, logic [63:0] e_addr,
                                bit e_idv, logic [63:0] e_pc, logic [31:0] e_instr);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rsp = rsp; v.data = data; v.redir = redir;
        v.rpc = rpc; v.idr = idr; v.e_req = e_req; v.e_addr = e_addr;
        v.e_idv = e_idv; v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    // ---------------- reference model and memory ----------------
    logic [95:0] exp_q[$];       // {pc, instr} in the order decode must see them
    logic [63:0] m_pc;
    logic [63:0] m_issue_pc;
    bit          m_out;          // a request is in flight
    bit          m_disc;         // its response must be thrown away
    bit          mem_pending;
    int          mem_cnt;
    logic [31:0] mem_data;
    int          fires;
    bit          s_req_valid;
    bit          s_id_valid;
    logic [63:0] s_addr;
    logic [63:0] s_id_pc;

    task automatic mcycle(input bit r, input bit idr, input bit redir,
                          input logic [63:0] rpc, input int lat, input bit rnd);
        bit          exp_req;
        bit          exp_idv;
        logic [95:0] hd;
        @(negedge clk);
        rst            = r;
        id_ready       = idr;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = !mem_pending && (!rnd || ($urandom_range(0, 3) != 0));
        if (mem_pending && mem_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data;
        end else begin
            imem_rsp_valid = rnd && !mem_pending && ($urandom_range(0, 7) == 0);
            imem_rsp_data  = $urandom;
        end
        #1;
        exp_req = !m_out && (exp_q.size() < 2) && !redir && !r;
        exp_idv = (exp_q.size() != 0) && !r;
        hd      = exp_idv ? exp_q[0] : '0;
        check("req_valid", imem_req_valid, exp_req);
        if (exp_req) check("req_addr", imem_req_addr, m_pc);
        check("id_valid", id_valid, exp_idv);
        check("id_pc", id_pc, hd[95:32]);
        check("id_instr", id_instr, hd[31:0]);
        check("id_opcode", id_opcode, hd[6:0]);
        s_req_valid = imem_req_valid;
        s_id_valid  = id_valid;
        s_addr      = imem_req_addr;
        s_id_pc     = id_pc;
        if (imem_req_valid && imem_req_ready) fires++;

        if (mem_pending) begin
            if (mem_cnt == 0) mem_pending = 1'b0;
            else mem_cnt--;
        end
        if (exp_req && imem_req_ready) begin
            mem_pending = 1'b1;
            mem_cnt     = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
            mem_data    = $urandom;
        end

        if (r) begin
            m_pc   = 64'h0;
            m_out  = 1'b0;
            m_disc = 1'b0;
            exp_q.delete();
        end else if (redir) begin
            exp_q.delete();
            m_pc = {rpc[63:2], 2'b00};
            if (m_out) begin
                if (imem_rsp_valid) m_out = 1'b0;
                else m_disc = 1'b1;
            end
        end else begin
            if (exp_q.size() != 0 && idr) void'(exp_q.pop_front());
            if (m_out && imem_rsp_valid) begin
                if (!m_disc) exp_q.push_back({m_issue_pc, imem_rsp_data});
                m_out  = 1'b0;
                m_disc = 1'b0;
            end
            if (exp_req && imem_req_ready) begin
                m_issue_pc = m_pc;
                m_pc       = m_pc + 64'd4;
                m_out      = 1'b1;
                m_disc     = 1'b0;
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        mem_pending = 1'b0;
        mcycle(1'b1, 1'b0, 1'b0, 64'h0, 0, 1'b0);
        mcycle(1'b1, 1'b0, 1'b0, 64'h0, 0, 1'b0);
    endtask

    int idv_seen;

    initial begin
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        w_rst = 1'b1; w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = '0;
        w_redirect_valid = 1'b0; w_redirect_pc = '0; w_id_ready = 1'b0;
        m_pc = '0; m_issue_pc = '0; m_out = 1'b0; m_disc = 1'b0;
        mem_pending = 1'b0; mem_cnt = 0; mem_data = '0; fires = 0;

        //          rst rdy rsp data          rdr rpc        idr  req addr       idv pc         instr
        vecs[0]  = mk(1, 1, 0, 32'h0,        0, 64'h0,    0,   0, 64'h0,    0, 64'h0,    32'h0);
        vecs[1]  = mk(1, 1, 0, 32'h0,        0, 64'h0,    0,   0, 64'h0,    0, 64'h0,    32'h0);
        vecs[2]  = mk(0, 1, 0, 32'h0,        0, 64'h0,    0,   1, 64'h0,    0, 64'h0,    32'h0);
        vecs[3]  = mk(0, 1, 1, 32'h00100093, 0, 64'h0,    0,   0, 64'h0,    0, 64'h0,    32'h0);
        vecs[4]  = mk(0, 1, 0, 32'h0,        0, 64'h0,    0,   1, 64'h4,    1, 64'h0,    32'h00100093);
        vecs[5]  = mk(0, 1, 1, 32'h00200113, 0, 64'h0,    0,   0, 64'h0,    1, 64'h0,    32'h00100093);
        vecs[6]  = mk(0, 1, 0, 32'h0,        0, 64'h0,    0,   0, 64'h0,    1, 64'h0,    32'h00100093);
        vecs[7]  = mk(0, 1, 0, 32'h0,        0, 64'h0,    1,   0, 64'h0,    1, 64'h0,    32'h00100093);
        vecs[8]  = mk(0, 1, 0, 32'h0,        0, 64'h0,    1,   1, 64'h8,    1, 64'h4,    32'h00200113);
        vecs[9]  = mk(0, 1, 0, 32'h0,        0, 64'h0,    0,   0, 64'h0,    0, 64'h0,    32'h0);
        vecs[10] = mk(0, 1, 0, 32'h0,        1, 64'h1003, 0,   0, 64'h0,    0, 64'h0,    32'h0);
        vecs[11] = mk(0, 1, 1, 32'hDEADBEEF, 0, 64'h0,    0,   0, 64'h0,    0, 64'h0,    32'h0);
        vecs[12] = mk(0, 0, 0, 32'h0,        0, 64'h0,    0,   1, 64'h1000, 0, 64'h0,    32'h0);
        vecs[13] = mk(0, 1, 0, 32'h0,        0, 64'h0,    0,   1, 64'h1000, 0, 64'h0,    32'h0);
        vecs[14] = mk(0, 1, 1, 32'h12345678, 1, 64'h2000, 0,   0, 64'h0,    0, 64'h0,    32'h0);
        vecs[15] = mk(0, 1, 0, 32'h0,        0, 64'h0,    0,   1, 64'h2000, 0, 64'h0,    32'h0);
        vecs[16] = mk(0, 1, 1, 32'h00000013, 0, 64'h0,    0,   0, 64'h0,    0, 64'h0,    32'h0);
        vecs[17] = mk(0, 0, 0, 32'h0,        0, 64'h0,    1,   1, 64'h2004, 1, 64'h2000, 32'h00000013);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rst            = vecs[i].rst;
            imem_req_ready = vecs[i].rdy;
            imem_rsp_valid = vecs[i].rsp;
            imem_rsp_data  = vecs[i].data;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            id_ready       = vecs[i].idr;
            #1;
            check($sformatf("v%0d_req_valid", i), imem_req_valid, vecs[i].e_req);
            if (vecs[i].e_req) check($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].e_addr);
            check($sformatf("v%0d_id_valid", i), id_valid, vecs[i].e_idv);
            check($sformatf("v%0d_id_pc", i), id_pc, vecs[i].e_pc);
            check($sformatf("v%0d_id_instr", i), id_instr, vecs[i].e_instr);
            check($sformatf("v%0d_id_opcode", i), id_opcode, vecs[i].e_instr[6:0]);
        end

        // Decode stalled for 10 cycles: buffer fills to two and fetch stops.
        do_reset();
        #1;
        check("reset_state", dbg_state, IDLE);
        fires = 0;
        repeat (10) mcycle(1'b0, 1'b0, 1'b0, 64'h0, 0, 1'b0);
        check("stall_fires", fires, 2);
        check("stall_req_low", s_req_valid, 1'b0);
        check("stall_id_valid", s_id_valid, 1'b1);
        mcycle(1'b0, 1'b1, 1'b0, 64'h0, 0, 1'b0);
        check("drain_first_pc", s_id_pc, 64'h0);
        mcycle(1'b0, 1'b1, 1'b0, 64'h0, 0, 1'b0);
        check("drain_second_pc", s_id_pc, 64'h4);

        // Reset while a request is in flight; its late response must be ignored.
        do_reset();
        mcycle(1'b0, 1'b1, 1'b0, 64'h0, 3, 1'b0);
        mcycle(1'b1, 1'b1, 1'b0, 64'h0, 3, 1'b0);
        mcycle(1'b0, 1'b1, 1'b0, 64'h0, 0, 1'b0);
        check("post_reset_addr", s_addr, 64'h0);
        idv_seen = 0;
        repeat (4) begin
            mcycle(1'b0, 1'b1, 1'b0, 64'h0, 5, 1'b0);
            if (s_id_valid) idv_seen++;
        end
        check("stale_rsp_ignored", idv_seen, 0);

        // PC wrap from the top of the address space.
        @(negedge w_rst or negedge clk);
        @(negedge clk);
        w_rst = 1'b0; w_req_ready = 1'b1;
        #1;
        check("wrap_first_req", w_req_valid, 1'b1);
        check("wrap_first_addr", w_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk);
        w_rsp_valid = 1'b1; w_rsp_data = 32'h00000013;
        #1;
        check("wrap_wait_req", w_req_valid, 1'b0);
        @(negedge clk);
        w_rsp_valid = 1'b0;
        #1;
        check("wrap_second_req", w_req_valid, 1'b1);
        check("wrap_second_addr", w_req_addr, 64'h0);
        check("wrap_id_pc", w_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        w_rst = 1'b1;

        // Randomized traffic with redirects, spurious responses and resets.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            mcycle($urandom_range(0, 99) == 0,
                   $urandom_range(0, 9) < 7,
                   $urandom_range(0, 19) == 0,
                   {$urandom, $urandom},
                   -1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of fetched-instruction buffer entries; only the value 2 is supported.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; every flop is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port imem_req_valid, output, 1 bit, fetch request valid.
REQ-006 SHALL have port imem_req_ready, input, 1 bit, memory accepts the request.
REQ-007 SHALL have port imem_req_addr, output, 64 bits, fetch byte address.
REQ-008 SHALL have port imem_rsp_valid, input, 1 bit, instruction word returned.
REQ-009 SHALL have port imem_rsp_data, input, 32 bits, instruction word.
REQ-010 SHALL have port redirect_valid, input, 1 bit, branch/jump redirect.
REQ-011 SHALL have port redirect_pc, input, 64 bits, redirect target.
REQ-012 SHALL have port id_valid, output, 1 bit, instruction available to decode.
REQ-013 SHALL have port id_ready, input, 1 bit, decode consumes the instruction.
REQ-014 SHALL have port id_instr, output, 32 bits, instruction at the FIFO head.
REQ-015 SHALL have port id_pc, output, 64 bits, PC of id_instr.
REQ-016 SHALL have port id_opcode, output, 7 bits, equal to id_instr[6:0]; it drives the immediate-type decoder.

Function
REQ-017 SHALL hold pc_q, a 64-bit register; redirect_pc[1:0] SHALL be forced to 2'b00 when loaded.
REQ-018 SHALL implement the FSM states IDLE (nothing outstanding), WAIT (one request outstanding) and KILL (one request outstanding whose response must be discarded).
REQ-019 SHALL drive imem_req_valid = (state==IDLE) && (fifo_count<2) && !redirect_valid && !rst; imem_req_addr SHALL equal pc_q.
REQ-020 SHALL, on a handshake (imem_req_valid && imem_req_ready), go IDLE->WAIT and set pc_q <= pc_q+4 modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC wraps to 0).
REQ-021 SHALL, in WAIT with imem_rsp_valid, push {pc_q-4, imem_rsp_data} into the FIFO and go to IDLE.
REQ-022 SHALL make a pushed entry visible on id_* in the following cycle, so the minimum memory-response-to-id_valid latency is 1 cycle.
REQ-023 SHALL limit sustained throughput to one instruction per 2 cycles, with at most one request outstanding.
REQ-024 SHALL, in KILL with imem_rsp_valid, drop the response and go to IDLE.
REQ-025 SHALL ignore imem_rsp_valid while in IDLE.
REQ-026 SHALL, on redirect_valid, flush the FIFO, set pc_q <= {redirect_pc[63:2],2'b00}, and move WAIT->KILL, KILL->KILL, IDLE->IDLE.
REQ-027 SHALL, if imem_rsp_valid arrives in WAIT in the same cycle as redirect_valid, drop the response and go to IDLE.
REQ-028 SHALL pop the FIFO when id_valid && id_ready.
REQ-029 SHALL allow a push and a pop in the same cycle, leaving the count unchanged.
REQ-030 SHALL ignore a pop in a redirect cycle, because the flush dominates.
REQ-031 SHALL drive id_valid = (fifo_count != 0); when id_valid is 0, id_instr, id_pc and id_opcode SHALL be 0.
REQ-032 SHALL never overflow the FIFO, since an issue requires fifo_count<2 and only the response can push.

Reset
REQ-033 SHALL, when rst is high, set state=IDLE, pc_q=RESET_PC, fifo_count=0, FIFO pointers=0, and FIFO storage=0.
REQ-034 SHALL hold all outputs at 0 during reset; imem_req_valid SHALL first rise in the cycle after rst falls, with addr=RESET_PC.
REQ-035 SHALL ignore a response to a request in flight when reset asserts, since the state is then IDLE.
REQ-036 SHALL give reset priority over redirect_valid, imem_rsp_valid and id_ready.

Structure
REQ-037 SHALL place XLEN=64, ILEN=32, the RESET_PC default and the fetch-state enum encoding (IDLE=2'd0, WAIT=2'd1, KILL=2'd2) in the shared package rv_pkg.
REQ-038 SHALL implement the 2-entry FIFO as sub-module fetch_fifo with push, pop, flush, count and head outputs; the FSM and PC stay in if_stage.

Verification
REQ-039 SHALL verify: reset release with ready=1 and a 1-cycle response latency -> requests at 0x0, 0x4, 0x8, each 2 cycles apart; id_pc=0x0 with id_opcode=7'b0010011 for instruction 0x00100093.
REQ-040 SHALL verify: id_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req_valid held 0, no request beyond 0x4; on id_ready=1 both drain in order.
REQ-041 SHALL verify: redirect_valid with redirect_pc=0x1003 while in WAIT -> the FIFO empties, the late response is dropped (no id_valid), and the next request addr is 0x1000.
REQ-042 SHALL verify: imem_rsp_valid and redirect_valid in the same cycle -> the response is discarded and the next request addr equals the redirect target.
REQ-043 SHALL verify: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> the second request addr is 0x0.
REQ-044 SHALL verify: rst asserted mid-WAIT, then the response arrives after rst drops -> it is ignored, and the request addr is RESET_PC.
